contador_regressivo: RTL and testbench
======================================

Name: contador_regressivo

Overview:
- Loadable down-counter (countdown timer) with a small control FSM.
- Complements the existing up-counter: it counts down from a loaded value to zero and pulses `fim` at terminal count.
- Optional auto-reload gives a periodic tick.
- Used as a timeout or period generator beside datapath blocks; single clock domain.

Parameters:
- LARGURA, 5, width of the count and load value in bits.
- DIVISOR, 4, prescaler ratio; used only when CONTADOR_REGRESSIVO_PRESCALER_EN is defined; legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- carga  input  1  load strobe; captures valor_inicial and starts a countdown.
- valor_inicial  input  LARGURA  start value; sampled only when carga=1.
- habilita  input  1  count enable; counting advances only when it is 1.
- pausa  input  1  level; holds the count while 1.
- recarga  input  1  auto-reload mode; sampled in state FIM.
- contagem  output  LARGURA  current count, registered.
- fim  output  1  one-cycle pulse when contagem reaches 0; registered.
- ocupado  output  1  high in CONTANDO and PAUSADO.

Behaviour:
- Reset (reset=1 at a clk edge):
  - Outputs: contagem=0, fim=0, ocupado=0.
  - Internal state: state=IDLE, saved reload value=0, prescaler=0.
  - Priority: reset beats every other input.
- FSM states: IDLE, CONTANDO, PAUSADO, FIM. All outputs come from registers; no combinational input-to-output path.
- carga priority:
  - carga=1 in any state (reset=0) takes priority over pausa, habilita and recarga.
  - Next cycle: contagem=valor_inicial, saved value=valor_inicial, prescaler cleared.
  - If valor_inicial≠0: state=CONTANDO.
  - If valor_inicial=0: state=FIM, fim=1 on that same next cycle.
- IDLE:
  - Hold contagem; ocupado=0; fim=0.
  - Exit only via carga.
- CONTANDO, evaluated in this order:
  - If pausa=1: go to PAUSADO; contagem holds.
  - Else if habilita=0: contagem holds; stay in CONTANDO.
  - Else if contagem>1: decrement by 1.
  - Else (contagem=1): next cycle contagem=0, state=FIM, fim=1.
- PAUSADO:
  - contagem holds; ocupado stays 1; habilita ignored.
  - pausa=0 returns to CONTANDO next cycle; no decrement on that transition cycle.
- FIM (lasts exactly one cycle; fim=1 only in this state):
  - If recarga=1: next cycle contagem=saved value and state=CONTANDO. If saved value=0, next state is FIM again, so fim stays high continuously.
  - If recarga=0: next state IDLE, contagem stays 0.
- Period with recarga=1 and habilita held at 1: the sequence is N, N-1, …, 1, 0, N, …, which is N+1 cycles per fim pulse.
- Width rules:
  - Arithmetic is unsigned, LARGURA bits.
  - No underflow: the FSM never decrements from 0.
  - Maximum load is 2^LARGURA-1.
- Mid-operation events:
  - carga during CONTANDO, PAUSADO or FIM restarts cleanly; any pending fim is suppressed.
  - reset mid-count returns to IDLE on the next edge.
- Simultaneous pausa=1 and contagem=1 with habilita=1: pausa wins; no fim until resumed.

Optional Feature:
- Macro: CONTADOR_REGRESSIVO_PRESCALER_EN.
- When defined:
  - An internal prescaler counts enabled, unpaused cycles in CONTANDO.
  - contagem decrements only when the prescaler reaches DIVISOR-1; the prescaler then wraps to 0.
  - The prescaler clears on reset, on carga, on reload from FIM, and on entry to PAUSADO.
  - Period per count step = DIVISOR enabled cycles.
  - fim behaviour is otherwise unchanged.
- When not defined: no prescaler logic is built, DIVISOR is ignored, and contagem decrements every enabled cycle.

Test Plan:
- Load: reset 2 cycles; carga=1 with valor_inicial=5; habilita=1, recarga=0 → contagem 5,4,3,2,1,0. fim=1 only in the cycle showing 0, then IDLE with ocupado=0, contagem held at 0.
- Auto-reload: valor_inicial=3, recarga=1, habilita=1 for 12 cycles → contagem 3,2,1,0,3,2,1,0,… with a fim pulse every 4 cycles; ocupado=0 only in FIM cycles.
- Pause/enable: valor_inicial=6; pausa=1 for 3 cycles when contagem=4, then habilita=0 for 2 cycles → contagem holds 4 across 5+ cycles, then resumes 3,2,1,0; exactly one fim.
- Zero/max: carga with valor_inicial=0 → fim=1 next cycle, then IDLE. carga with 31 (LARGURA=5) → 32 cycles to fim, no wrap.
- Priority: carga=1 with valor_inicial=7 at contagem=2 → next contagem=7 and no fim. reset=1 at contagem=4 → next cycle contagem=0, fim=0, ocupado=0. carga and reset together → reset wins.
- Prescaler (macro defined, DIVISOR=4): valor_inicial=2, habilita=1 → contagem changes every 4 cycles and fim appears 8 cycles after the load value is visible. Without the macro, the same stimulus gives fim after 2 cycles.

Source files
------------

// File: rtl/contador_regressivo.sv
// contador_regressivo: loadable down-counter with a small control FSM.
// Counts from a loaded value down to zero, pulses `fim` for one cycle at
// terminal count and can optionally reload itself for a periodic tick.
// Optional feature: define CONTADOR_REGRESSIVO_PRESCALER_EN to insert a
// prescaler so that each count step takes DIVISOR enabled cycles.
// All outputs are registered; reset is synchronous and active-high.
module contador_regressivo #(
  parameter int LARGURA = 5,
  parameter int DIVISOR = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               carga,
  input  logic [LARGURA-1:0] valor_inicial,
  input  logic               habilita,
  input  logic               pausa,
  input  logic               recarga,
  output logic [LARGURA-1:0] contagem,
  output logic               fim,
  output logic               ocupado
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    FIM      = 2'd3
  } estado_t;

  localparam logic [LARGURA-1:0] ZERO_C = {LARGURA{1'b0}};
  localparam logic [LARGURA-1:0] UM_C   = {{(LARGURA-1){1'b0}}, 1'b1};

  estado_t            state_q, state_d;
  logic [LARGURA-1:0] contagem_q, contagem_d;
  logic [LARGURA-1:0] salvo_q, salvo_d;
  logic               fim_q, fim_d;
  logic               ocupado_q, ocupado_d;

  // One enabled, unpaused cycle spent counting (before any prescaling).
  logic               avanca_s;
  // Count step strobe: the counter moves down by one when this is high.
  logic               passo_s;

  // DIVISOR only matters with the prescaler, but an out-of-range value is
  // always a configuration mistake, so catch it at elaboration.
  if (DIVISOR < 2 || DIVISOR > 255) begin : g_divisor_invalido
    $error("contador_regressivo: DIVISOR must be in 2..255");
  end

  // Decide whether this cycle is an enabled counting cycle.
  always_comb begin
    avanca_s = 1'b0;
    if (state_q == CONTANDO && !carga && !pausa && habilita) begin
      avanca_s = 1'b1;
    end else begin
      avanca_s = 1'b0;
    end
  end

`ifdef CONTADOR_REGRESSIVO_PRESCALER_EN
  localparam int PW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [PW-1:0] PRESC_MAX_C = PW'(DIVISOR - 1);
  localparam logic [PW-1:0] PRESC_UM_C  = PW'(1);

  logic [PW-1:0] presc_q, presc_d;

  // Prescaler next value: cleared on load, on leaving FIM and on entering
  // PAUSADO; wraps to zero when it releases a count step.
  always_comb begin
    presc_d = presc_q;
    passo_s = 1'b0;
    if (carga) begin
      presc_d = {PW{1'b0}};
    end else if (state_q == FIM) begin
      presc_d = {PW{1'b0}};
    end else if (state_q == CONTANDO && pausa) begin
      presc_d = {PW{1'b0}};
    end else if (avanca_s) begin
      if (presc_q == PRESC_MAX_C) begin
        presc_d = {PW{1'b0}};
        passo_s = 1'b1;
      end else begin
        presc_d = presc_q + PRESC_UM_C;
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= {PW{1'b0}};
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  // Without the prescaler every enabled cycle is a count step.
  always_comb begin
    passo_s = avanca_s;
  end
`endif

  // Next-state, next-count and registered-output logic of the control FSM.
  always_comb begin
    state_d    = state_q;
    contagem_d = contagem_q;
    salvo_d    = salvo_q;
    if (carga) begin
      // A load restarts cleanly from any state and suppresses pending fim.
      contagem_d = valor_inicial;
      salvo_d    = valor_inicial;
      if (valor_inicial != ZERO_C) begin
        state_d = CONTANDO;
      end else begin
        state_d = FIM;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        CONTANDO: begin
          if (pausa) begin
            state_d = PAUSADO;
          end else if (passo_s) begin
            // Never decrement from zero: the last step lands on FIM.
            if (contagem_q > UM_C) begin
              contagem_d = contagem_q - UM_C;
              state_d    = CONTANDO;
            end else begin
              contagem_d = ZERO_C;
              state_d    = FIM;
            end
          end else begin
            state_d = CONTANDO;
          end
        end
        PAUSADO: begin
          // Resuming costs one cycle with no decrement.
          if (!pausa) begin
            state_d = CONTANDO;
          end else begin
            state_d = PAUSADO;
          end
        end
        FIM: begin
          if (recarga) begin
            // A saved value of zero keeps us in FIM, so fim stays high.
            contagem_d = salvo_q;
            if (salvo_q != ZERO_C) begin
              state_d = CONTANDO;
            end else begin
              state_d = FIM;
            end
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d    = IDLE;
          contagem_d = ZERO_C;
        end
      endcase
    end

    fim_d     = (state_d == FIM);
    ocupado_d = (state_d == CONTANDO) || (state_d == PAUSADO);
  end

  // FSM, count, saved-value and output registers; reset beats everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      contagem_q <= ZERO_C;
      salvo_q    <= ZERO_C;
      fim_q      <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      contagem_q <= contagem_d;
      salvo_q    <= salvo_d;
      fim_q      <= fim_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign contagem = contagem_q;
  assign fim      = fim_q;
  assign ocupado  = ocupado_q;

endmodule

// File: tb/tb_contador_regressivo.sv
// Self-checking bench for contador_regressivo: a directed vector table,
// hand-written multi-cycle sequences and a randomized run compared against
// a behavioural reference model.
module tb_contador_regressivo;

  localparam int LARGURA = 5;
  localparam int DIVISOR = 4;
`ifdef CONTADOR_REGRESSIVO_PRESCALER_EN
  localparam int PASSO = DIVISOR;
`else
  localparam int PASSO = 1;
`endif

  logic               clk = 1'b0;
  logic               reset, carga, habilita, pausa, recarga;
  logic [LARGURA-1:0] valor_inicial;
  logic [LARGURA-1:0] contagem;
  logic               fim, ocupado;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  contador_regressivo #(.LARGURA(LARGURA), .DIVISOR(DIVISOR)) dut (
    .clk          (clk),
    .reset        (reset),
    .carga        (carga),
    .valor_inicial(valor_inicial),
    .habilita     (habilita),
    .pausa        (pausa),
    .recarga      (recarga),
    .contagem     (contagem),
    .fim          (fim),
    .ocupado      (ocupado)
  );

  // ---------------- reference model ----------------
  int m_cnt, m_saved, m_ticks;
  bit m_busy, m_paused, m_fim;

  task automatic model_update(input bit r, input bit c, input int v,
                              input bit h, input bit p, input bit rc);
    if (r) begin
      m_cnt = 0; m_saved = 0; m_ticks = 0;
      m_busy = 0; m_paused = 0; m_fim = 0;
    end else if (c) begin
      m_cnt = v; m_saved = v; m_ticks = 0;
      m_fim = (v == 0); m_busy = (v != 0); m_paused = 0;
    end else if (m_fim) begin
      m_paused = 0;
      if (rc) begin
        m_cnt = m_saved; m_ticks = 0;
        m_fim = (m_saved == 0); m_busy = (m_saved != 0);
      end else begin
        m_fim = 0; m_busy = 0;
      end
    end else if (m_busy && m_paused) begin
      if (!p) m_paused = 0;
    end else if (m_busy) begin
      if (p) begin
        m_paused = 1; m_ticks = 0;
      end else if (h) begin
        m_ticks++;
        if (m_ticks == PASSO) begin
          m_ticks = 0;
          m_cnt--;
          if (m_cnt == 0) begin
            m_fim = 1; m_busy = 0;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle.
  task automatic step(input bit r, input bit c, input int v,
                      input bit h, input bit p, input bit rc);
    reset = r; carga = c; valor_inicial = LARGURA'(v);
    habilita = h; pausa = p; recarga = rc;
    @(posedge clk);
    model_update(r, c, v, h, p, rc);
    #1;
  endtask

  task automatic check(input string name, input int ec, input bit ef, input bit eo);
    n_tests++;
    if (contagem !== LARGURA'(ec) || fim !== ef || ocupado !== eo) begin
      n_fail++;
      $display("FAIL %s: got contagem=%0d fim=%0b ocupado=%0b, expected contagem=%0d fim=%0b ocupado=%0b",
               name, contagem, fim, ocupado, ec, ef, eo);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit r; bit c; int v; bit h; bit p; bit rc;
    int ec; bit ef; bit eo;
    string name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit c, input int v, input bit h, input bit p,
                     input bit rc, input int ec, input bit ef, input bit eo, input string name);
    vec_t x;
    x.r = r; x.c = c; x.v = v; x.h = h; x.p = p; x.rc = rc;
    x.ec = ec; x.ef = ef; x.eo = eo; x.name = name;
    tbl.push_back(x);
  endtask

  initial begin
    reset = 1'b1; carga = 1'b0; valor_inicial = '0;
    habilita = 1'b0; pausa = 1'b0; recarga = 1'b0;
    model_update(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);

`ifndef CONTADOR_REGRESSIVO_PRESCALER_EN
    //   r  c  v  h  p  rc   cnt fim ocup
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, "reset1");
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, "reset2");
    add(0, 1, 5, 1, 0, 0,   5, 0, 1, "load5");
    add(0, 0, 0, 1, 0, 0,   4, 0, 1, "dec4");
    add(0, 0, 0, 1, 0, 0,   3, 0, 1, "dec3");
    add(0, 0, 0, 1, 0, 0,   2, 0, 1, "dec2");
    add(0, 0, 0, 1, 0, 0,   1, 0, 1, "dec1");
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, "term0");
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, "idle_a");
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, "idle_b");
    add(0, 1, 3, 1, 0, 1,   3, 0, 1, "ar_load3");
    add(0, 0, 0, 1, 0, 1,   2, 0, 1, "ar2");
    add(0, 0, 0, 1, 0, 1,   1, 0, 1, "ar1");
    add(0, 0, 0, 1, 0, 1,   0, 1, 0, "ar_fim1");
    add(0, 0, 0, 1, 0, 1,   3, 0, 1, "ar_reload");
    add(0, 0, 0, 1, 0, 1,   2, 0, 1, "ar2b");
    add(0, 0, 0, 1, 0, 1,   1, 0, 1, "ar1b");
    add(0, 0, 0, 1, 0, 1,   0, 1, 0, "ar_fim2");
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, "ar_stop");
    add(0, 1, 0, 0, 0, 0,   0, 1, 0, "zero_load");
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, "zero_idle");
    add(0, 1, 4, 1, 0, 0,   4, 0, 1, "pr_load4");
    add(0, 0, 0, 1, 0, 0,   3, 0, 1, "pr3");
    add(0, 0, 0, 1, 0, 0,   2, 0, 1, "pr2");
    add(0, 1, 7, 1, 0, 0,   7, 0, 1, "pr_reload7");
    add(0, 0, 0, 1, 0, 0,   6, 0, 1, "pr6");
    add(0, 0, 0, 1, 0, 0,   5, 0, 1, "pr5");
    add(0, 0, 0, 1, 0, 0,   4, 0, 1, "pr4");
    add(1, 0, 0, 1, 0, 0,   0, 0, 0, "pr_reset");
    add(1, 1, 9, 1, 0, 0,   0, 0, 0, "reset_beats_carga");
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, "after_reset_idle");
    add(0, 1, 0, 0, 0, 1,   0, 1, 0, "zero_rel_a");
    add(0, 0, 0, 0, 0, 1,   0, 1, 0, "zero_rel_b");
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, "zero_rel_end");
    add(0, 1, 6, 1, 0, 0,   6, 0, 1, "pa_load6");
    add(0, 0, 0, 1, 0, 0,   5, 0, 1, "pa5");
    add(0, 0, 0, 1, 0, 0,   4, 0, 1, "pa4");
    add(0, 0, 0, 1, 1, 0,   4, 0, 1, "pa_hold1");
    add(0, 0, 0, 1, 1, 0,   4, 0, 1, "pa_hold2");
    add(0, 0, 0, 1, 1, 0,   4, 0, 1, "pa_hold3");
    add(0, 0, 0, 1, 0, 0,   4, 0, 1, "pa_resume");
    add(0, 0, 0, 0, 0, 0,   4, 0, 1, "en_off1");
    add(0, 0, 0, 0, 0, 0,   4, 0, 1, "en_off2");
    add(0, 0, 0, 1, 0, 0,   3, 0, 1, "pa3");
    add(0, 0, 0, 1, 0, 0,   2, 0, 1, "pa2");
    add(0, 0, 0, 1, 0, 0,   1, 0, 1, "pa1");
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, "pa_fim");
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, "pa_idle");
    add(0, 1, 1, 1, 0, 0,   1, 0, 1, "sim_load1");
    add(0, 0, 0, 1, 1, 0,   1, 0, 1, "sim_pause_wins");
    add(0, 0, 0, 1, 0, 0,   1, 0, 1, "sim_resume");
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, "sim_fim");
    add(0, 1, 1, 1, 0, 0,   1, 0, 1, "fs_load1");
    add(0, 0, 0, 1, 0, 0,   0, 1, 0, "fs_fim");
    add(0, 1, 2, 1, 0, 1,   2, 0, 1, "fs_carga_in_fim");
    add(0, 0, 0, 1, 0, 1,   1, 0, 1, "fs1");
    add(0, 0, 0, 1, 0, 1,   0, 1, 0, "fs_fim2");
    add(0, 1, 3, 1, 1, 0,   3, 0, 1, "carga_beats_pausa");

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].h, tbl[i].p, tbl[i].rc);
      check(tbl[i].name, tbl[i].ec, tbl[i].ef, tbl[i].eo);
    end
`endif

    // Maximum load: counts all the way down with no wrap.
    step(1, 0, 0, 0, 0, 0);
    check("max_reset", 0, 1'b0, 1'b0);
    step(0, 1, 31, 1, 0, 0);
    check("max_load", 31, 1'b0, 1'b1);
    for (int k = 1; k <= 31 * PASSO; k++) begin
      step(0, 0, 0, 1, 0, 0);
      check("max_seq", 31 - k / PASSO, k == 31 * PASSO, k != 31 * PASSO);
    end
    step(0, 0, 0, 1, 0, 0);
    check("max_after", 0, 1'b0, 1'b0);

    // Load 2: fim after 2 steps (2*DIVISOR cycles with the prescaler).
    step(0, 1, 2, 1, 0, 0);
    check("two_load", 2, 1'b0, 1'b1);
    for (int k = 1; k <= 2 * PASSO; k++) begin
      step(0, 0, 0, 1, 0, 0);
      check("two_seq", 2 - k / PASSO, k == 2 * PASSO, k != 2 * PASSO);
    end

    // Randomized run against the reference model.
    step(1, 0, 0, 0, 0, 0);
    check("rand_reset", m_cnt, m_fim, m_busy);
    for (int n = 0; n < 3000; n++) begin
      bit r, c, h, p, rc;
      int v;
      r  = ($urandom_range(0, 79) == 0);
      c  = ($urandom_range(0, 15) == 0);
      v  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
      h  = ($urandom_range(0, 3) != 0);
      p  = ($urandom_range(0, 7) == 0);
      rc = $urandom_range(0, 1) == 1;
      step(r, c, v, h, p, rc);
      check("rand", m_cnt, m_fim, m_busy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
